// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared FSM state, BCD digit type, digit limits and a digit increment helper.
package stopwatch_pkg;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t DIG_MAX9 = 4'd9;
    localparam bcd_t DIG_MAX5 = 4'd5;

    function automatic bcd_t bcd_inc(input bcd_t d, input bcd_t lim);
        return (d == lim) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/rise_tick.sv
// rise_tick: registered rising-edge detector turning the sampled divided clock into one-cycle ticks.
//   clk, rst : system clock, asynchronous active-high reset
//   sig_i    : level input, already synchronous to clk
//   tick_o   : one-cycle pulse, registered, one per rising edge of sig_i
module rise_tick (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic tick_o
);

    logic prev_q;
    logic primed_q;
    logic tick_q;

    // The first sample after reset only loads prev_q, so an input that is
    // already high when reset releases is not mistaken for a rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q   <= 1'b0;
            primed_q <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            prev_q   <= sig_i;
            primed_q <= 1'b1;
            tick_q   <= primed_q & sig_i & ~prev_q;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/stopwatch_bcd.sv
// stopwatch_bcd: mm:ss BCD stopwatch driven by a 100 Hz divided clock, with start/stop/clear control.
//   TICKS_PER_SEC : div_clk rising edges per counted second (>= 2)
//   clk, rst      : system clock, asynchronous active-high reset
//   div_clk       : divided clock sampled as data
//   start/stop/clear : level commands, priority clear > stop > start
//   sec_ones, sec_tens, min_ones, min_tens : BCD count
//   running       : high in RUN;  wrap : one-cycle pulse on 59:59 -> 00:00
//   Optional STOPWATCH_LAP_EN adds lap input plus lap_* digits and lap_valid.
module stopwatch_bcd
    import stopwatch_pkg::*;
#(
    parameter int TICKS_PER_SEC = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       div_clk,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       running,
    output logic       wrap
`ifdef STOPWATCH_LAP_EN
    ,
    input  logic       lap,
    output logic [3:0] lap_sec_ones,
    output logic [3:0] lap_sec_tens,
    output logic [3:0] lap_min_ones,
    output logic [3:0] lap_min_tens,
    output logic       lap_valid
`endif
);

    localparam int PW = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0] PMAX = PW'(TICKS_PER_SEC - 1);

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    bcd_t          so_q, so_d, st_q, st_d, mo_q, mo_d, mt_q, mt_d;
    logic          wrap_q, wrap_d;
    logic          tick, advance, sec_tick, c1, c2, c3;

    rise_tick u_rise (
        .clk    (clk),
        .rst    (rst),
        .sig_i  (div_clk),
        .tick_o (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // stop dominates start: in IDLE it is a no-op, anywhere else it parks in PAUSE.
    always_comb begin
        state_d = clear ? IDLE
                : stop  ? ((state_q == IDLE) ? IDLE : PAUSE)
                : start ? RUN
                : state_q;
    end

    // A tick only counts when the machine is in RUN and stays there this cycle.
    always_comb begin
        running = (state_q == RUN);
        advance = tick && (state_q == RUN) && !clear && !stop;
    end

    always_comb begin
        sec_tick = advance && (presc_q == PMAX);
        c1       = sec_tick && (so_q == DIG_MAX9);
        c2       = c1 && (st_q == DIG_MAX5);
        c3       = c2 && (mo_q == DIG_MAX9);
        wrap_d   = c3 && (mt_q == DIG_MAX5);
        presc_d  = clear ? '0 : advance ? (sec_tick ? '0 : presc_q + 1'b1) : presc_q;
        so_d     = clear ? 4'd0 : sec_tick ? bcd_inc(so_q, DIG_MAX9) : so_q;
        st_d     = clear ? 4'd0 : c1 ? bcd_inc(st_q, DIG_MAX5) : st_q;
        mo_d     = clear ? 4'd0 : c2 ? bcd_inc(mo_q, DIG_MAX9) : mo_q;
        mt_d     = clear ? 4'd0 : c3 ? bcd_inc(mt_q, DIG_MAX5) : mt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            so_q    <= 4'd0;
            st_q    <= 4'd0;
            mo_q    <= 4'd0;
            mt_q    <= 4'd0;
            wrap_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            so_q    <= so_d;
            st_q    <= st_d;
            mo_q    <= mo_d;
            mt_q    <= mt_d;
            wrap_q  <= wrap_d;
        end
    end

    assign sec_ones = so_q;
    assign sec_tens = st_q;
    assign min_ones = mo_q;
    assign min_tens = mt_q;
    assign wrap     = wrap_q;

`ifdef STOPWATCH_LAP_EN
    logic [15:0] lap_q, lap_d;
    logic        lapv_q, lapv_d;

    // Captures the digits as displayed before this edge's update.
    always_comb begin
        lap_d  = clear ? 16'd0 : (lap && state_q == RUN) ? {mt_q, mo_q, st_q, so_q} : lap_q;
        lapv_d = clear ? 1'b0  : (lap && state_q == RUN) ? 1'b1 : lapv_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lap_q  <= 16'd0;
            lapv_q <= 1'b0;
        end else begin
            lap_q  <= lap_d;
            lapv_q <= lapv_d;
        end
    end

    assign {lap_min_tens, lap_min_ones, lap_sec_tens, lap_sec_ones} = lap_q;
    assign lap_valid = lapv_q;
`endif

endmodule

// File: tb/tb_stopwatch_bcd.sv
// tb_stopwatch_bcd: randomized scoreboard bench comparing stopwatch_bcd against a tick-count reference model.
module tb_stopwatch_bcd;

    localparam int TPS  = 4;
    localparam int FULL = TPS * 3600;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       div_clk = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       clear = 1'b0;
    logic       lap = 1'b0;
    logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
    logic       running, wrap;
`ifdef STOPWATCH_LAP_EN
    logic [3:0] lap_sec_ones, lap_sec_tens, lap_min_ones, lap_min_tens;
    logic       lap_valid;
`endif

    always #5 clk = ~clk;

    stopwatch_bcd #(.TICKS_PER_SEC(TPS)) dut (
        .clk      (clk),
        .rst      (rst),
        .div_clk  (div_clk),
        .start    (start),
        .stop     (stop),
        .clear    (clear),
        .sec_ones (sec_ones),
        .sec_tens (sec_tens),
        .min_ones (min_ones),
        .min_tens (min_tens),
        .running  (running),
        .wrap     (wrap)
`ifdef STOPWATCH_LAP_EN
        ,
        .lap          (lap),
        .lap_sec_ones (lap_sec_ones),
        .lap_sec_tens (lap_sec_tens),
        .lap_min_ones (lap_min_ones),
        .lap_min_tens (lap_min_tens),
        .lap_valid    (lap_valid)
`endif
    );

    typedef struct packed {
        logic [15:0] dig;
        logic        run;
        logic        wr;
        logic [15:0] lapd;
        logic        lapv;
    } obs_t;

    obs_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_wrap = 0;

    // Reference model: elapsed RUN ticks as one integer; digits derived by division.
    int m_state = 0;
    int m_cnt = 0;
    int m_lap = 0;
    bit m_tick = 0, m_prev = 0, m_primed = 0, m_wrap = 0, m_lapv = 0;

    function automatic logic [15:0] bcd4(input int cnt);
        int s;
        s = cnt / TPS;
        return {4'(s / 600), 4'((s / 60) % 10), 4'((s % 60) / 10), 4'(s % 10)};
    endfunction

    function automatic obs_t sample();
        obs_t a;
        a.dig = {min_tens, min_ones, sec_tens, sec_ones};
        a.run = running;
        a.wr  = wrap;
`ifdef STOPWATCH_LAP_EN
        a.lapd = {lap_min_tens, lap_min_ones, lap_sec_tens, lap_sec_ones};
        a.lapv = lap_valid;
`else
        a.lapd = 16'd0;
        a.lapv = 1'b0;
`endif
        return a;
    endfunction

    always @(negedge clk) begin
        if (q.size() > 0) begin
            obs_t e, a;
            e = q.pop_front();
            a = sample();
            n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL outputs t=%0t got dig=%h run=%b wrap=%b lap=%h/%b want dig=%h run=%b wrap=%b lap=%h/%b",
                         $time, a.dig, a.run, a.wr, a.lapd, a.lapv, e.dig, e.run, e.wr, e.lapd, e.lapv);
            end
            if (wrap) n_wrap++;
        end
    end

    task automatic cyc(input bit r, input bit d, input bit sa, input bit sp, input bit cl, input bit lp);
        obs_t e, a;
        bit   counted;
        @(negedge clk);
        #1;
        div_clk = d;
        start   = sa;
        stop    = sp;
        clear   = cl;
        lap     = lp;
        if (r && !rst) begin
            #2;
            rst = 1'b1;
            #1;
            a = sample();
            n_cmp++;
            if (a !== '0) begin
                n_bad++;
                $display("FAIL async_reset got dig=%h run=%b wrap=%b lap=%h/%b want all zero",
                         a.dig, a.run, a.wr, a.lapd, a.lapv);
            end
        end else begin
            rst = r;
        end
        if (r) begin
            m_state = 0; m_cnt = 0; m_lap = 0; m_lapv = 0;
            m_tick = 0; m_prev = 0; m_primed = 0; m_wrap = 0;
        end else begin
            counted = m_tick && m_state == 1 && !cl && !sp;
            m_wrap = 0;
            if (cl) begin
                m_cnt = 0; m_lap = 0; m_lapv = 0;
            end else begin
                if (lp && m_state == 1) begin
                    m_lap = m_cnt; m_lapv = 1;
                end
                if (counted) begin
                    m_cnt++;
                    if (m_cnt == FULL) begin
                        m_cnt = 0; m_wrap = 1;
                    end
                end
            end
            if (cl) m_state = 0;
            else if (sp) m_state = (m_state == 1) ? 2 : m_state;
            else if (sa) m_state = 1;
            m_tick = m_primed && d && !m_prev;
            m_prev = d;
            m_primed = 1;
        end
        e.dig = bcd4(m_cnt);
        e.run = (m_state == 1);
        e.wr  = m_wrap;
`ifdef STOPWATCH_LAP_EN
        e.lapd = bcd4(m_lap);
        e.lapv = m_lapv;
`else
        e.lapd = 16'd0;
        e.lapv = 1'b0;
`endif
        q.push_back(e);
    endtask

    task automatic edges(input int n, input bit fast);
        for (int i = 0; i < n; i++) begin
            int h, l;
            h = fast ? 1 : $urandom_range(1, 3);
            l = fast ? 1 : $urandom_range(1, 3);
            for (int j = 0; j < h; j++) cyc(0, 1, 0, 0, 0, 0);
            for (int j = 0; j < l; j++) cyc(0, 0, 0, 0, 0, 0);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        edges(8, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 1, 0, 0, 0);
        edges(22, 1);
        cyc(0, 0, 0, 1, 0, 0);
        edges(10, 0);
        cyc(0, 0, 1, 0, 0, 0);
        edges(2, 1);
        cyc(0, 0, 0, 0, 0, 0);
        edges(6, 1);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 1, 1, 1, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 300; i++)
            cyc(0, 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 1, 0, 0, 0);
        edges(37 * TPS, 1);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0, 0);
        edges(8, 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 1, 0, 0, 0);
        edges(83 * TPS, 1);
        cyc(0, 0, 0, 0, 0, 1);
        edges(4, 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 1, 0, 0, 0);
        edges(FULL + 3, 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        n_cmp++;
        if (n_wrap != 1) begin
            n_bad++;
            $display("FAIL wrap_count got %0d want 1", n_wrap);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
